// File: rtl/iic_eeprom_slave.sv
// iic_eeprom_slave: IIC slave that emulates a byte-addressable EEPROM.
// SCL/SDA are oversampled on clk. Storage is an internal register array.
// The slave adds a write-cycle busy window; the device address is NACKed
// while that window runs, so a master can poll for completion.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   SCL, SDA_in: IIC bus inputs (asynchronous to clk)
//   WP         : write protect, level-sensitive
//   SDA_out    : data to the open-drain pad logic
//   SDA_oe     : 1 = drive SDA_out onto the bus, 0 = release
//   busy       : high while the internal write cycle runs
module iic_eeprom_slave #(
  parameter logic [6:0]  DEV_ADDR   = 7'h50,
  parameter int unsigned ADDR_BYTES = 1,
  parameter int unsigned MEM_DEPTH  = 256,
  parameter int unsigned PAGE_SIZE  = 8,
  parameter int unsigned HOLD_CLKS  = 10,
  parameter int unsigned TWR_CLKS   = 26'd50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SCL,
  input  logic SDA_in,
  input  logic WP,
  output logic SDA_out,
  output logic SDA_oe,
  output logic busy
);

  localparam int unsigned ADDR_W = $clog2(MEM_DEPTH);
  localparam int unsigned HOLD_W = $clog2(HOLD_CLKS + 1);
  localparam int unsigned TWR_W  = $clog2(TWR_CLKS + 1);
  localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_SIZE - 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_DEV       = 4'd1;
  localparam logic [3:0] S_DEV_ACK   = 4'd2;
  localparam logic [3:0] S_ADDR      = 4'd3;
  localparam logic [3:0] S_ADDR_ACK  = 4'd4;
  localparam logic [3:0] S_WDATA     = 4'd5;
  localparam logic [3:0] S_WDATA_ACK = 4'd6;
  localparam logic [3:0] S_RDATA     = 4'd7;
  localparam logic [3:0] S_RACK      = 4'd8;
  localparam logic [3:0] S_WAIT_STOP = 4'd9;

  logic [2:0]        scl_sr, sda_sr;
  logic [1:0]        wp_sr;
  logic              scl_s, scl_d, sda_s, sda_d, wp_s;
  logic              scl_rise, scl_fall, start_c, stop_c;
  logic [3:0]        state;
  logic [3:0]        bit_cnt;
  logic [7:0]        shreg;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] ptr, addr_acc, ptr_page_next;
  logic              addr_idx;
  logic              written;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TWR_W-1:0]  wr_timer;
  logic              mem_we;
  logic [7:0]        mem [MEM_DEPTH];

  // Index 1 is the synchronised value, index 2 its 1-cycle delayed copy.
  assign scl_s    = scl_sr[1];
  assign scl_d    = scl_sr[2];
  assign sda_s    = sda_sr[1];
  assign sda_d    = sda_sr[2];
  assign wp_s     = wp_sr[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & ~sda_s & sda_d;
  assign stop_c   = scl_s & scl_d & sda_s & ~sda_d;
  assign rx_byte  = {shreg[6:0], sda_s};
  assign busy     = (wr_timer != '0);

  // Page-wrapping increment: only the in-page offset bits advance.
  assign ptr_page_next = (ptr & ~PAGE_MASK) | ((ptr + ADDR_W'(1)) & PAGE_MASK);

  // Data byte is committed on the falling edge that ends its ACK bit.
  assign mem_we = scl_fall & ~start_c & ~stop_c & (state == S_WDATA_ACK) & (bit_cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (mem_we) mem[ptr] <= shreg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sr   <= '1;
      sda_sr   <= '1;
      wp_sr    <= '0;
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      addr_acc <= '0;
      addr_idx <= 1'b0;
      written  <= 1'b0;
      hold_cnt <= '0;
      wr_timer <= '0;
      SDA_out  <= 1'b1;
      SDA_oe   <= 1'b0;
    end else begin
      scl_sr <= {scl_sr[1:0], SCL};
      sda_sr <= {sda_sr[1:0], SDA_in};
      wp_sr  <= {wp_sr[0], WP};

      if (wr_timer != '0) wr_timer <= wr_timer - TWR_W'(1);

      if (start_c) begin
        state    <= S_DEV;
        bit_cnt  <= '0;
        addr_idx <= 1'b0;
        hold_cnt <= '0;
        SDA_oe   <= 1'b0;
        SDA_out  <= 1'b1;
      end else if (stop_c) begin
        state    <= S_IDLE;
        bit_cnt  <= '0;
        hold_cnt <= '0;
        SDA_oe   <= 1'b0;
        SDA_out  <= 1'b1;
        if (written) begin
          written  <= 1'b0;
          wr_timer <= TWR_W'(TWR_CLKS);
        end
      end else begin
        // Output update HOLD_CLKS cycles after the SCL falling edge, chosen
        // from the state reached at that falling edge.
        if (hold_cnt != '0) begin
          hold_cnt <= hold_cnt - HOLD_W'(1);
          if (hold_cnt == HOLD_W'(1)) begin
            case (state)
              S_DEV_ACK, S_ADDR_ACK, S_WDATA_ACK: begin
                SDA_oe  <= 1'b1;
                SDA_out <= 1'b0;
              end
              S_RDATA: begin
                SDA_oe  <= 1'b1;
                SDA_out <= shreg[7];
              end
              default: begin
                SDA_oe  <= 1'b0;
                SDA_out <= 1'b1;
              end
            endcase
          end
        end
        if (scl_fall) hold_cnt <= HOLD_W'(HOLD_CLKS);

        // ACK states are entered on the 8th rising edge; the 9th rising edge
        // clears bit_cnt so the following falling edge leaves the state.
        if (scl_rise) begin
          case (state)
            S_DEV: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7)
                state <= (rx_byte[7:1] == DEV_ADDR && !busy) ? S_DEV_ACK : S_WAIT_STOP;
            end
            S_ADDR: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                addr_acc <= ADDR_W'({addr_acc, rx_byte});
                state    <= S_ADDR_ACK;
              end
            end
            S_WDATA: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) state <= wp_s ? S_WAIT_STOP : S_WDATA_ACK;
            end
            S_RDATA: begin
              shreg   <= rx_byte;
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd7) begin
                state <= S_RACK;
                ptr   <= ptr + ADDR_W'(1);
              end
            end
            S_DEV_ACK, S_ADDR_ACK, S_WDATA_ACK: bit_cnt <= '0;
            S_RACK: begin
              if (sda_s) state <= S_WAIT_STOP;
              else       bit_cnt <= '0;
            end
            default: ;
          endcase
        end else if (scl_fall && bit_cnt == 4'd0) begin
          case (state)
            S_DEV_ACK: begin
              if (shreg[0]) begin
                state <= S_RDATA;
                shreg <= mem[ptr];
              end else begin
                state <= S_ADDR;
              end
            end
            S_ADDR_ACK: begin
              if (addr_idx == 1'(ADDR_BYTES - 1)) begin
                ptr   <= addr_acc;
                state <= S_WDATA;
              end else begin
                addr_idx <= addr_idx + 1'b1;
                state    <= S_ADDR;
              end
            end
            S_WDATA_ACK: begin
              ptr     <= ptr_page_next;
              written <= 1'b1;
              state   <= S_WDATA;
            end
            S_RACK: begin
              state <= S_RDATA;
              shreg <= mem[ptr];
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_iic_eeprom_slave.sv
// tb_iic_eeprom_slave: directed bench for iic_eeprom_slave. Two instances
// share one bit-banged master: dut0 (1 address byte, 256 bytes, TWR 100)
// and dut1 (2 address bytes, 1024 bytes, TWR 2000). The idle instance sees
// SCL/SDA held high. Read data is checked through an expected-byte queue.
`timescale 1ns/1ps
module tb_iic_eeprom_slave;

  localparam int Q = 100;  // quarter SCL period in ns

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, scl, msda, sel, wp;
  logic scl0, scl1, sda0, sda1;
  logic out0, oe0, busy0, out1, oe1, busy1;
  logic bus_sel, oe_sel, busy_sel;

  assign scl0     = sel ? 1'b1 : scl;
  assign scl1     = sel ? scl : 1'b1;
  assign sda0     = (sel ? 1'b1 : msda) & ~(oe0 & ~out0);
  assign sda1     = (sel ? msda : 1'b1) & ~(oe1 & ~out1);
  assign bus_sel  = sel ? sda1 : sda0;
  assign oe_sel   = sel ? oe1 : oe0;
  assign busy_sel = sel ? busy1 : busy0;

  iic_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_BYTES(1), .MEM_DEPTH(256),
                     .PAGE_SIZE(8), .HOLD_CLKS(10), .TWR_CLKS(100)) dut0 (
    .clk(clk), .rst_n(rst_n), .SCL(scl0), .SDA_in(sda0), .WP(wp),
    .SDA_out(out0), .SDA_oe(oe0), .busy(busy0));

  iic_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_BYTES(2), .MEM_DEPTH(1024),
                     .PAGE_SIZE(8), .HOLD_CLKS(10), .TWR_CLKS(2000)) dut1 (
    .clk(clk), .rst_n(rst_n), .SCL(scl1), .SDA_in(sda1), .WP(wp),
    .SDA_out(out1), .SDA_oe(oe1), .busy(busy1));

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bit_io(input logic b, output logic r, output logic o);
    msda = b;
    #(Q); scl = 1'b1;
    #(Q); r = bus_sel; o = oe_sel;
    #(Q); scl = 1'b0;
    #(Q);
  endtask

  task automatic i2c_start();
    if (scl === 1'b0) begin
      msda = 1'b1; #(Q); scl = 1'b1; #(Q);
    end
    msda = 1'b0; #(Q); scl = 1'b0; #(Q);
  endtask

  task automatic i2c_stop();
    msda = 1'b0; #(Q); scl = 1'b1; #(Q); msda = 1'b1; #(Q);
  endtask

  task automatic stop_measure(output int hi);
    msda = 1'b0; #(Q); scl = 1'b1; #(Q); msda = 1'b1;
    hi = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_sel) hi++;
      else if (hi > 0) break;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe_ack,
                           output logic oe_any);
    logic r, o;
    oe_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      bit_io(b[i], r, o);
      oe_any = oe_any | o;
    end
    bit_io(1'b1, ack, oe_ack);
    oe_any = oe_any | oe_ack;
  endtask

  task automatic wr_byte(input string tag, input logic [7:0] b);
    logic a, oa, any;
    send_byte(b, a, oa, any);
    chk(tag, {30'd0, oa, a}, 32'b10);
  endtask

  task automatic nk_byte(input string tag, input logic [7:0] b, output logic any);
    logic a, oa;
    send_byte(b, a, oa, any);
    chk(tag, {30'd0, oa, a}, 32'b01);
  endtask

  task automatic rd_byte(input string tag, input logic mack);
    logic [7:0] d;
    logic r, o;
    for (int i = 7; i >= 0; i--) begin
      bit_io(1'b1, r, o);
      d[i] = r;
    end
    bit_io(mack, r, o);
    chk({tag, "_mack_oe"}, {31'd0, o}, 32'd0);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed %0h expected <queue empty>", tag, d);
    end else begin
      chk(tag, {24'd0, d}, {24'd0, exp_q.pop_front()});
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 5000 && busy_sel; i++) @(negedge clk);
    chk(tag, {31'd0, busy_sel}, 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wdat [8];
    logic any, seen;
    int hi;
    wdat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    rst_n = 1'b0; scl = 1'b1; msda = 1'b1; sel = 1'b0; wp = 1'b0;
    #100;
    chk("rst_oe0", {31'd0, oe0}, 32'd0);
    chk("rst_out0", {31'd0, out0}, 32'd1);
    chk("rst_busy0", {31'd0, busy0}, 32'd0);
    chk("rst_oe1", {31'd0, oe1}, 32'd0);
    rst_n = 1'b1;
    #100;

    // Page write at 0x23, wrapping inside page 0x20..0x27.
    i2c_start();
    wr_byte("w_dev", 8'hA0);
    wr_byte("w_addr", 8'h23);
    for (int i = 0; i < 8; i++) wr_byte("w_data", wdat[i]);
    stop_measure(hi);
    chk("busy_len", hi, 100);

    // Random read from 0x20 across the wrapped page.
    i2c_start();
    wr_byte("rr_dev_w", 8'hA0);
    wr_byte("rr_addr", 8'h20);
    i2c_start();
    wr_byte("rr_dev_r", 8'hA1);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    for (int i = 0; i < 5; i++) rd_byte("rr_data", (i == 4));
    #(Q);
    chk("rr_nack_release", {31'd0, oe_sel}, 32'd0);
    i2c_stop();

    // Seed 0x40 for the write-protect check.
    i2c_start();
    wr_byte("s_dev", 8'hA0);
    wr_byte("s_addr", 8'h40);
    wr_byte("s_data", 8'h3C);
    i2c_stop();
    wait_idle("s_idle");

    // Foreign device address: nothing ACKed, SDA never driven.
    i2c_start();
    seen = 1'b0;
    nk_byte("mm_dev", 8'hA2, any); seen = seen | any;
    nk_byte("mm_b1", 8'h20, any);  seen = seen | any;
    nk_byte("mm_b2", 8'h99, any);  seen = seen | any;
    nk_byte("mm_b3", 8'h99, any);  seen = seen | any;
    chk("mm_oe_never", {31'd0, seen}, 32'd0);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("mm_no_busy", {31'd0, busy_sel}, 32'd0);

    // Write protect: data byte NACKed, no write cycle.
    wp = 1'b1;
    #100;
    i2c_start();
    wr_byte("wp_dev", 8'hA0);
    wr_byte("wp_addr", 8'h40);
    nk_byte("wp_data", 8'h5A, any);
    i2c_stop();
    repeat (20) @(negedge clk);
    chk("wp_no_busy", {31'd0, busy_sel}, 32'd0);
    wp = 1'b0;
    #100;

    i2c_start();
    wr_byte("v_dev_w", 8'hA0);
    wr_byte("v_addr", 8'h40);
    i2c_start();
    wr_byte("v_dev_r", 8'hA1);
    exp_q.push_back(8'h3C);
    rd_byte("v_wp_mem", 1'b1);
    i2c_start();
    wr_byte("v2_dev_w", 8'hA0);
    wr_byte("v2_addr", 8'h20);
    i2c_start();
    wr_byte("v2_dev_r", 8'hA1);
    exp_q.push_back(8'h66); exp_q.push_back(8'h77); exp_q.push_back(8'h88);
    for (int i = 0; i < 3; i++) rd_byte("v2_mm_mem", (i == 2));
    i2c_stop();

    // Second instance: 2-byte addressing, 1024 bytes.
    #200;
    sel = 1'b1;
    #200;
    i2c_start();
    wr_byte("d1_dev", 8'hA0); wr_byte("d1_ah", 8'h03); wr_byte("d1_al", 8'hF8);
    wr_byte("d1_data", 8'hC3);
    i2c_stop();
    wait_idle("d1_idle_a");
    i2c_start();
    wr_byte("d1_dev", 8'hA0); wr_byte("d1_ah", 8'h00); wr_byte("d1_al", 8'h00);
    wr_byte("d1_data", 8'h5E);
    i2c_stop();
    wait_idle("d1_idle_b");
    i2c_start();
    wr_byte("d1_dev", 8'hA0); wr_byte("d1_ah", 8'h03); wr_byte("d1_al", 8'hFF);
    wr_byte("d1_data", 8'hAB);
    i2c_stop();

    // ACK polling while the write cycle runs.
    chk("poll_busy", {31'd0, busy_sel}, 32'd1);
    i2c_start();
    nk_byte("poll_nack", 8'hA0, any);
    i2c_stop();
    wait_idle("poll_idle");
    i2c_start();
    wr_byte("poll_ack", 8'hA0);

    // Current-address read: pointer wrapped within page 0x3F8..0x3FF.
    i2c_start();
    wr_byte("cur_dev_r", 8'hA1);
    exp_q.push_back(8'hC3);
    rd_byte("cur_rd", 1'b1);
    i2c_stop();

    // Random read at 0x3FF wraps the pointer to 0x000.
    i2c_start();
    wr_byte("wr_dev", 8'hA0); wr_byte("wr_ah", 8'h03); wr_byte("wr_al", 8'hFF);
    i2c_start();
    wr_byte("wr_dev_r", 8'hA1);
    exp_q.push_back(8'hAB); exp_q.push_back(8'h5E);
    rd_byte("wrap_rd", 1'b0);
    rd_byte("wrap_rd", 1'b1);
    i2c_stop();

    // Asynchronous reset in the middle of a read releases SDA at once.
    i2c_start();
    wr_byte("rst_dev_r", 8'hA1);
    begin
      logic r, o;
      bit_io(1'b1, r, o);
      chk("rd_oe_pre_rst", {31'd0, oe_sel}, 32'd1);
      #3; rst_n = 1'b0;
      #1;
      chk("rd_oe_rst", {31'd0, oe_sel}, 32'd0);
      chk("rd_out_rst", {31'd0, out1}, 32'd1);
    end
    #50;
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
